// File: rtl/wb_port_arbiter_if.sv
// Bundle of the Writeback-side and MDU-side signals that meet at the
// register-file write port, plus the resulting write-port outputs.
interface wb_port_arbiter_if;
  logic        RegWrite_WB;
  logic [4:0]  RD_WB;
  logic [63:0] WBData_WB;
  logic        MDU_Valid;
  logic [4:0]  MDU_RD;
  logic [63:0] MDU_Data;
  logic        MDU_Ready;
  logic        Stall_WB;
  logic        RegWrite_ID;
  logic [4:0]  RD_ID;
  logic [63:0] WriteData_ID;
  logic [31:0] Pending_Mask;

  // Arbiter side: consumes requests and drives the register-file port
  modport slave (
    input  RegWrite_WB, RD_WB, WBData_WB, MDU_Valid, MDU_RD, MDU_Data,
    output MDU_Ready, Stall_WB, RegWrite_ID, RD_ID, WriteData_ID, Pending_Mask
  );

  // Requester side: pipeline Writeback and MDU, observing the port
  modport master (
    output RegWrite_WB, RD_WB, WBData_WB, MDU_Valid, MDU_RD, MDU_Data,
    input  MDU_Ready, Stall_WB, RegWrite_ID, RD_ID, WriteData_ID, Pending_Mask
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter. Writeback results pass straight
// through; late MDU results wait in a small FIFO and drain into idle
// port cycles. A starvation counter steals one cycle from Writeback
// (Stall_WB) when the FIFO head has waited STARVE_LIMIT cycles.
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int ZERO_REG     = 31
) (
  input  logic            clk,
  input  logic            resetl,
  wb_port_arbiter_if.slave bus
);

  localparam int          PW      = $clog2(DEPTH);
  localparam int          CW      = PW + 1;
  localparam logic [4:0]  ZERO_RD = 5'(ZERO_REG);
  localparam logic [3:0]  LIMIT   = 4'(STARVE_LIMIT);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    starveCnt_q, starveCnt_d;
  logic [4:0]    fifoRd_q   [DEPTH];
  logic [63:0]   fifoData_q [DEPTH];

  logic        fifoEmpty;
  logic        fifoFull;
  logic        pipeReq;
  logic        atLimit;
  logic        drain;
  logic        forced;
  logic        push;
  logic [31:0] pendingMask;

  // Grant decision from registered FIFO state and the current requests
  always_comb begin
    fifoEmpty = (count_q == '0);
    fifoFull  = (count_q == FULL_COUNT);
    pipeReq   = bus.RegWrite_WB && (bus.RD_WB != ZERO_RD);
    atLimit   = (starveCnt_q == LIMIT);
    drain     = !fifoEmpty && (!pipeReq || atLimit);
    forced    = !fifoEmpty && pipeReq && atLimit;
    push      = !resetl && !fifoFull && bus.MDU_Valid && (bus.MDU_RD != ZERO_RD);
  end

  // Next pointer, occupancy and starvation count; the counter only ticks
  // while the head is waiting behind a pipeline write
  always_comb begin
    wrPtr_d     = push  ? wrPtr_q + 1'b1 : wrPtr_q;
    rdPtr_d     = drain ? rdPtr_q + 1'b1 : rdPtr_q;
    count_d     = count_q + CW'(push) - CW'(drain);
    starveCnt_d = starveCnt_q;
    if (fifoEmpty || drain) begin
      starveCnt_d = '0;
    end else if (pipeReq) begin
      starveCnt_d = starveCnt_q + 4'd1;
    end
  end

  // One-hot OR of the destination of every occupied FIFO slot
  always_comb begin
    pendingMask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q) begin
        pendingMask[fifoRd_q[rdPtr_q + PW'(i)]] = 1'b1;
      end
    end
  end

  // Port outputs, all held at zero while reset is asserted
  always_comb begin
    bus.MDU_Ready    = 1'b0;
    bus.Stall_WB     = 1'b0;
    bus.RegWrite_ID  = 1'b0;
    bus.RD_ID        = '0;
    bus.WriteData_ID = '0;
    bus.Pending_Mask = '0;
    if (!resetl) begin
      bus.MDU_Ready    = !fifoFull;
      bus.Stall_WB     = forced;
      bus.RegWrite_ID  = drain || pipeReq;
      bus.Pending_Mask = pendingMask;
      if (drain) begin
        bus.RD_ID        = fifoRd_q[rdPtr_q];
        bus.WriteData_ID = fifoData_q[rdPtr_q];
      end else begin
        bus.RD_ID        = bus.RD_WB;
        bus.WriteData_ID = bus.WBData_WB;
      end
    end
  end

  // Control state: reset discards every queued entry
  always_ff @(posedge clk) begin
    if (resetl) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      starveCnt_q <= '0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      starveCnt_q <= starveCnt_d;
    end
  end

  // FIFO storage; contents are don't-care until the count covers them
  always_ff @(posedge clk) begin
    if (push) begin
      fifoRd_q[wrPtr_q]   <= bus.MDU_RD;
      fifoData_q[wrPtr_q] <= bus.MDU_Data;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: each step drives one cycle of
// requests, queues the port result that cycle must show, and compares
// it against the DUT at the falling edge.
module tb_wb_port_arbiter;

  logic clk;
  logic resetl;
  int   passCount;
  int   totalCount;

  typedef struct {
    string       tag;
    logic        we;
    logic [4:0]  rd;
    logic [63:0] data;
    logic        stall;
    logic        ready;
    logic [31:0] mask;
  } exp_t;

  exp_t sbQ[$];

  wb_port_arbiter_if bus ();

  wb_port_arbiter #(
    .DEPTH(2),
    .STARVE_LIMIT(4),
    .ZERO_REG(31)
  ) dut (
    .clk(clk),
    .resetl(resetl),
    .bus(bus.slave)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalCount++;
    assert (obs === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("[TB] check %s did not match", tag);
    end
  endtask

  // Pops the oldest expectation and compares every port output
  task automatic checkOutput();
    exp_t e;
    if (sbQ.size() == 0) begin
      totalCount++;
      $display("[TB] FAIL scoreboard observed=empty expected=entry");
      return;
    end
    e = sbQ.pop_front();
    checkVal({e.tag, ".RegWrite_ID"},  64'(bus.RegWrite_ID),  64'(e.we));
    checkVal({e.tag, ".RD_ID"},        64'(bus.RD_ID),        64'(e.rd));
    checkVal({e.tag, ".WriteData_ID"}, bus.WriteData_ID,      e.data);
    checkVal({e.tag, ".Stall_WB"},     64'(bus.Stall_WB),     64'(e.stall));
    checkVal({e.tag, ".MDU_Ready"},    64'(bus.MDU_Ready),    64'(e.ready));
    checkVal({e.tag, ".Pending_Mask"}, 64'(bus.Pending_Mask), 64'(e.mask));
  endtask

  // Drives one cycle, records what the port must show, checks mid-cycle
  task automatic applyStimulus(
    input string       tag,
    input logic        we,  input logic [4:0] rd,  input logic [63:0] data,
    input logic        mv,  input logic [4:0] mrd, input logic [63:0] mdata,
    input logic        eWe, input logic [4:0] eRd, input logic [63:0] eData,
    input logic        eStall, input logic eReady, input logic [31:0] eMask
  );
    exp_t e;
    bus.RegWrite_WB = we;
    bus.RD_WB       = rd;
    bus.WBData_WB   = data;
    bus.MDU_Valid   = mv;
    bus.MDU_RD      = mrd;
    bus.MDU_Data    = mdata;
    e.tag   = tag;
    e.we    = eWe;
    e.rd    = eRd;
    e.data  = eData;
    e.stall = eStall;
    e.ready = eReady;
    e.mask  = eMask;
    sbQ.push_back(e);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  // Directed sequence
  initial begin
    passCount  = 0;
    totalCount = 0;
    resetl = 1'b1;
    bus.RegWrite_WB = 1'b0;
    bus.RD_WB       = '0;
    bus.WBData_WB   = '0;
    bus.MDU_Valid   = 1'b0;
    bus.MDU_RD      = '0;
    bus.MDU_Data    = '0;
    @(posedge clk);
    #1;

    applyStimulus("rst0", 1, 5'd3, 64'h33, 1, 5'd6, 64'h66, 0, 5'd0, 64'h0, 0, 0, 32'h0);
    applyStimulus("rst1", 1, 5'd3, 64'h33, 1, 5'd6, 64'h66, 0, 5'd0, 64'h0, 0, 0, 32'h0);
    resetl = 1'b0;
    applyStimulus("postrst", 0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 0, 1, 32'h0);

    applyStimulus("idle.enq",  0, 5'd0, 64'h0, 1, 5'd5, 64'hDEAD, 0, 5'd0, 64'h0, 0, 1, 32'h0);
    applyStimulus("idle.drn",  0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 1, 5'd5, 64'hDEAD, 0, 1, 32'h1 << 5);
    applyStimulus("idle.done", 0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 0, 1, 32'h0);

    applyStimulus("stv.enq", 0, 5'd0, 64'h0, 1, 5'd7, 64'h77, 0, 5'd0, 64'h0, 0, 1, 32'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus($sformatf("stv.pipe%0d", i), 1, 5'd3, 64'h33, 0, 5'd0, 64'h0,
                    1, 5'd3, 64'h33, 0, 1, 32'h1 << 7);
    end
    applyStimulus("stv.force", 1, 5'd3, 64'h33, 0, 5'd0, 64'h0, 1, 5'd7, 64'h77, 1, 1, 32'h1 << 7);
    applyStimulus("stv.held",  1, 5'd3, 64'h33, 0, 5'd0, 64'h0, 1, 5'd3, 64'h33, 0, 1, 32'h0);
    applyStimulus("stv.idle",  0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 0, 1, 32'h0);

    applyStimulus("full.x1",  1, 5'd3, 64'h33, 1, 5'd1, 64'h11, 1, 5'd3, 64'h33, 0, 1, 32'h0);
    applyStimulus("full.x2",  1, 5'd3, 64'h33, 1, 5'd2, 64'h22, 1, 5'd3, 64'h33, 0, 1, 32'h2);
    applyStimulus("full.x4a", 1, 5'd3, 64'h33, 1, 5'd4, 64'h44, 1, 5'd3, 64'h33, 0, 0, 32'h6);
    applyStimulus("full.x4b", 1, 5'd3, 64'h33, 1, 5'd4, 64'h44, 1, 5'd3, 64'h33, 0, 0, 32'h6);
    applyStimulus("full.x4c", 1, 5'd3, 64'h33, 1, 5'd4, 64'h44, 1, 5'd3, 64'h33, 0, 0, 32'h6);
    applyStimulus("full.frc", 1, 5'd3, 64'h33, 1, 5'd4, 64'h44, 1, 5'd1, 64'h11, 1, 0, 32'h6);
    applyStimulus("full.acc", 1, 5'd3, 64'h33, 1, 5'd4, 64'h44, 1, 5'd3, 64'h33, 0, 1, 32'h4);
    applyStimulus("full.bsy", 1, 5'd3, 64'h33, 0, 5'd0, 64'h0,  1, 5'd3, 64'h33, 0, 0, 32'h14);
    applyStimulus("full.dx2", 0, 5'd0, 64'h0,  0, 5'd0, 64'h0,  1, 5'd2, 64'h22, 0, 0, 32'h14);
    applyStimulus("full.dx4", 0, 5'd0, 64'h0,  0, 5'd0, 64'h0,  1, 5'd4, 64'h44, 0, 1, 32'h10);
    applyStimulus("full.end", 0, 5'd0, 64'h0,  0, 5'd0, 64'h0,  0, 5'd0, 64'h0,  0, 1, 32'h0);

    applyStimulus("zr.pipe",  1, 5'd31, 64'h3131, 0, 5'd0, 64'h0, 0, 5'd31, 64'h3131, 0, 1, 32'h0);
    applyStimulus("zr.enq",   0, 5'd0, 64'h0, 1, 5'd9, 64'h99, 0, 5'd0, 64'h0, 0, 1, 32'h0);
    applyStimulus("zr.drn",   1, 5'd31, 64'h3131, 0, 5'd0, 64'h0, 1, 5'd9, 64'h99, 0, 1, 32'h1 << 9);
    applyStimulus("zr.mdu",   0, 5'd0, 64'h0, 1, 5'd31, 64'hFFFF, 0, 5'd0, 64'h0, 0, 1, 32'h0);
    applyStimulus("zr.after", 0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 0, 1, 32'h0);

    applyStimulus("mid.e10", 1, 5'd3, 64'h33, 1, 5'd10, 64'hA, 1, 5'd3, 64'h33, 0, 1, 32'h0);
    applyStimulus("mid.e11", 1, 5'd3, 64'h33, 1, 5'd11, 64'hB, 1, 5'd3, 64'h33, 0, 1, 32'h1 << 10);
    resetl = 1'b1;
    applyStimulus("mid.rst", 1, 5'd3, 64'h33, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 0, 0, 32'h0);
    resetl = 1'b0;
    applyStimulus("mid.rel0", 0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 0, 1, 32'h0);
    applyStimulus("mid.rel1", 0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 0, 1, 32'h0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
